// File: rtl/muldiv_iter_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_iter_pkg : shared encodings for the iterative multiply/divide unit
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_iter_pkg;

   typedef enum logic [1:0] {
      c_md_mult  = 2'b00,
      c_md_multu = 2'b01,
      c_md_div   = 2'b10,
      c_md_divu  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      c_st_idle = 2'b00,
      c_st_calc = 2'b01,
      c_st_done = 2'b10
   } md_state_e;

   // Stall and ready levels shared with the EX stall logic
   localparam logic c_stop      = 1'b1;
   localparam logic c_nostop    = 1'b0;
   localparam logic c_ready     = 1'b1;
   localparam logic c_not_ready = 1'b0;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_step.sv
// ---------------------------------------------------------------------------
// muldiv_step : one combinational iteration (STEP bits) of shift-add multiply
//               or restoring divide over the {HI,LO} accumulator
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_step #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                 i_is_div,
   input  logic [WIDTH-1:0]     i_operand,
   input  logic [2*WIDTH-1:0]   i_acc,
   output logic [2*WIDTH-1:0]   o_acc
);

   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_trial;

   always_comb begin
      w_hi    = i_acc[2*WIDTH-1:WIDTH];
      w_lo    = i_acc[WIDTH-1:0];
      w_sum   = '0;
      w_trial = '0;
      for (int s = 0; s < STEP; s++) begin
         if (i_is_div) begin
            // Partial remainder stays below the divisor, so bit WIDTH is the sign
            w_trial = {w_hi, w_lo[WIDTH-1]} - {1'b0, i_operand};
            if (!w_trial[WIDTH])
               w_hi = w_trial[WIDTH-1:0];
            else
               w_hi = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
            w_lo = {w_lo[WIDTH-2:0], ~w_trial[WIDTH]};
         end else begin
            w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});
            w_hi  = w_sum[WIDTH:1];
            w_lo  = {w_sum[0], w_lo[WIDTH-1:1]};
         end
      end
      o_acc = {w_hi, w_lo};
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter : multi-cycle MULT/MULTU/DIV/DIVU unit returning {HI,LO}
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_i,
   input  logic [1:0]           op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 hilo_we_o
);

   localparam int N       = WIDTH / STEP;
   localparam int C_CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(N - 1);

   md_state_e            r_state;
   logic [C_CNT_W-1:0]   r_cnt;
   logic                 r_is_div;
   logic                 r_neg_res;
   logic                 r_neg_rem;
   logic [WIDTH-1:0]     r_operand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_ready;

   logic                 w_signed;
   logic                 w_sign1;
   logic                 w_sign2;
   logic [WIDTH-1:0]     w_mag1;
   logic [WIDTH-1:0]     w_mag2;
   logic                 w_div0;
   logic [2*WIDTH-1:0]   w_step_acc;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [2*WIDTH-1:0]   w_fixed;

   assign w_signed = ~op_i[0];
   assign w_sign1  = w_signed & opdata1_i[WIDTH-1];
   assign w_sign2  = w_signed & opdata2_i[WIDTH-1];
   assign w_mag1   = w_sign1 ? ({WIDTH{1'b0}} - opdata1_i) : opdata1_i;
   assign w_mag2   = w_sign2 ? ({WIDTH{1'b0}} - opdata2_i) : opdata2_i;
   assign w_div0   = op_i[1] & (opdata2_i == {WIDTH{1'b0}});

   muldiv_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .i_is_div  (r_is_div),
      .i_operand (r_operand),
      .i_acc     (r_acc),
      .o_acc     (w_step_acc)
   );

   // Sign fix-up on magnitudes; the most-negative quotient wraps on its own
   assign w_prod  = r_neg_res ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
   assign w_quo   = r_neg_res ? ({WIDTH{1'b0}} - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
   assign w_rem   = r_neg_rem ? ({WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH])
                              : r_acc[2*WIDTH-1:WIDTH];
   assign w_fixed = r_is_div ? {w_rem, w_quo} : w_prod;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= c_st_idle;
         r_cnt     <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_operand <= '0;
         r_acc     <= '0;
         r_result  <= '0;
         r_ready   <= c_not_ready;
      end else begin
         r_ready <= c_not_ready;
         case (r_state)
            c_st_idle: begin
               if (start_i && !annul_i) begin
                  r_is_div <= op_i[1];
                  r_cnt    <= '0;
                  if (w_div0) begin
                     r_operand <= w_mag2;
                     r_acc     <= {opdata1_i, {WIDTH{1'b1}}};
                     r_neg_res <= 1'b0;
                     r_neg_rem <= 1'b0;
                     r_state   <= c_st_done;
                  end else begin
                     r_operand <= op_i[1] ? w_mag2 : w_mag1;
                     r_acc     <= {{WIDTH{1'b0}}, (op_i[1] ? w_mag1 : w_mag2)};
                     r_neg_res <= w_sign1 ^ w_sign2;
                     r_neg_rem <= w_sign1;
                     r_state   <= c_st_calc;
                  end
               end
            end
            c_st_calc: begin
               if (annul_i) begin
                  r_state <= c_st_idle;
               end else begin
                  r_acc <= w_step_acc;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == C_LAST)
                     r_state <= c_st_done;
               end
            end
            c_st_done: begin
               r_state <= c_st_idle;
               if (!annul_i) begin
                  r_result <= w_fixed;
                  r_ready  <= c_ready;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign busy_o    = (r_state != c_st_idle) ? c_stop : c_nostop;
   assign ready_o   = r_ready & ~annul_i;
   assign hilo_we_o = ready_o;
   assign result_o  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter : directed self-checking bench for muldiv_iter (STEP 1 and 2)
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_iter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        sel;
   logic [1:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        annul;

   logic        busy1, ready1, hilo1;
   logic [63:0] result1;
   logic        busy2, ready2, hilo2;
   logic [63:0] result2;

   logic        busy_s, ready_s, hilo_s;
   logic [63:0] result_s;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   wire start1 = start & ~sel;
   wire start2 = start & sel;

   always #5 clk = ~clk;

   muldiv_iter #(.WIDTH(32), .STEP(1)) u_dut1 (
      .clk       (clk),
      .resetn    (resetn),
      .start_i   (start1),
      .op_i      (op),
      .opdata1_i (opa),
      .opdata2_i (opb),
      .annul_i   (annul),
      .busy_o    (busy1),
      .ready_o   (ready1),
      .result_o  (result1),
      .hilo_we_o (hilo1)
   );

   muldiv_iter #(.WIDTH(32), .STEP(2)) u_dut2 (
      .clk       (clk),
      .resetn    (resetn),
      .start_i   (start2),
      .op_i      (op),
      .opdata1_i (opa),
      .opdata2_i (opb),
      .annul_i   (annul),
      .busy_o    (busy2),
      .ready_o   (ready2),
      .result_o  (result2),
      .hilo_we_o (hilo2)
   );

   always_comb begin
      busy_s   = sel ? busy2   : busy1;
      ready_s  = sel ? ready2  : ready1;
      hilo_s   = sel ? hilo2   : hilo1;
      result_s = sel ? result2 : result1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int l);
      l = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (ready_s) begin
            l = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
      int l;
      op    = o;
      opa   = a;
      opb   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      op    = 2'($urandom_range(0, 3));
      check_val({tag, "_busy"}, 64'(busy_s), 64'd1);
      wait_ready(l);
      check_val({tag, "_lat"}, 64'(l), 64'(exp_lat));
      check_val({tag, "_res"}, result_s, exp);
      check_val({tag, "_we"}, 64'(hilo_s), 64'd1);
      check_val({tag, "_idle"}, 64'(busy_s), 64'd0);
      tick();
      check_val({tag, "_pulse"}, 64'(ready_s), 64'd0);
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      sel    = 1'b0;
      op     = 2'b00;
      opa    = '0;
      opb    = '0;
      annul  = 1'b0;
      tick();
      tick();
      check_val("rst_busy",  64'(busy1),  64'd0);
      check_val("rst_ready", 64'(ready1), 64'd0);
      check_val("rst_we",    64'(hilo1),  64'd0);
      check_val("rst_res",   result1,     64'd0);
      check_val("rst_busy2", 64'(busy2),  64'd0);
      resetn = 1'b1;
      tick();

      // STEP=1 unit
      run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33);
      run_op("mult_m2_3",  2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFFFFFF_FFFFFFFA, 33);
      run_op("multu_max2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h00000001_FFFFFFFE, 33);
      run_op("mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 33);
      run_op("divu_big",   2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000000F_0FFFFFFF, 33);
      run_op("div_7_m2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
      run_op("divu_by0",   2'b11, 32'd100,       32'h0000_0000, 64'h00000064_FFFFFFFF, 1);
      run_op("div_m5_by0", 2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFFFFFB_FFFFFFFF, 1);
      run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);

      // STEP=2 unit
      sel = 1'b1;
      run_op("s2_mult",  2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFFFFFF_FFFFFFFA, 17);
      run_op("s2_multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h00000001_FFFFFFFE, 17);
      run_op("s2_div",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 17);
      sel = 1'b0;

      // Abort in CALC cycle 10, then restart straight away
      op    = 2'b10;
      opa   = 32'd100;
      opb   = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check_val("annul_pre_busy", 64'(busy1), 64'd1);
      annul = 1'b1;
      tick();
      annul = 1'b0;
      check_val("annul_busy",  64'(busy1),  64'd0);
      check_val("annul_ready", 64'(ready1), 64'd0);
      run_op("after_annul", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

      // Asynchronous reset between edges in the middle of CALC
      op    = 2'b01;
      opa   = 32'd6;
      opb   = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2;
      resetn = 1'b0;
      #1;
      check_val("arst_busy", 64'(busy1), 64'd0);
      check_val("arst_res",  result1,    64'd0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      run_op("divu_9_4", 2'b11, 32'd9, 32'd4, 64'h00000001_00000002, 33);

      // start held high: one op per pass, operands sampled only at acceptance
      op    = 2'b01;
      opa   = 32'd3;
      opb   = 32'd5;
      start = 1'b1;
      tick();
      opa = 32'd7;
      opb = 32'd11;
      wait_ready(lat);
      check_val("hold1_lat",  64'(lat),   64'd33);
      check_val("hold1_res",  result1,    64'd15);
      check_val("hold1_idle", 64'(busy1), 64'd0);
      tick();
      start = 1'b0;
      opa   = 32'd100;
      opb   = 32'd100;
      check_val("hold2_busy", 64'(busy1), 64'd1);
      wait_ready(lat);
      check_val("hold2_lat", 64'(lat), 64'd33);
      check_val("hold2_res", result1,  64'd77);
      tick();
      check_val("hold2_pulse", 64'(ready1), 64'd0);
      repeat (40) tick();
      check_val("hold_no_extra", 64'(busy1), 64'd0);
      check_val("hold_res_kept", result1,    64'd77);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
